// File: rtl/line_buffer_pkg.sv
// Shared types and default geometry for the line-buffer frame sequencer.
package line_buffer_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} lb_state_t;

  localparam int DEF_IMG_WIDTH  = 6;
  localparam int DEF_IMG_HEIGHT = 6;
  localparam int DEF_LINE_NUM   = 3;
endpackage

// File: rtl/lb_pos_counter.sv
// Column/row position counter for the accepted pixel stream.
// Wraps on explicit compares, so non-power-of-2 geometries count correctly.
module lb_pos_counter
  import line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_pix
);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  assign last_col = (col == COL_MAX);
  assign last_pix = last_col && (row == ROW_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer: gates pixels into the line-buffer chain, tracks position
// and flags when a full LINE_NUM x LINE_NUM window sits at the buffer outputs.
//   state | meaning
//   IDLE  | waiting for start, pixels refused
//   FILL  | priming the first LINE_NUM-1 lines, no window yet possible
//   RUN   | windows may complete, runs to the last pixel of the frame
//   DONE  | one-cycle frame_done, then back to IDLE
module line_buffer_ctrl
  import line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int LINE_NUM   = DEF_LINE_NUM,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          valid_in,
  output logic          ready,
  output logic          lb_valid_in,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done,
  output logic          err_drop
);
  localparam logic [CW-1:0] COL_WIN  = CW'(LINE_NUM - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(LINE_NUM - 1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(LINE_NUM - 2);

  lb_state_t     state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col;
  logic          last_pix;
  logic          clr;

  assign ready       = (state == FILL) || (state == RUN);
  assign busy        = (state == FILL) || (state == RUN);
  assign lb_valid_in = valid_in && ready;
  assign clr         = (state == IDLE) && start;

  lb_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .en      (lb_valid_in),
    .col     (col),
    .row     (row),
    .last_col(last_col),
    .last_pix(last_pix)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      win_valid  <= 1'b0;
      if (lb_valid_in) begin
        win_col   <= col;
        win_row   <= row;
        win_valid <= (row >= ROW_WIN) && (col >= COL_WIN);
      end
      // a start in IDLE takes priority over a coincident pixel
      if (valid_in && !ready && !clr)
        err_drop <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state    <= (LINE_NUM > 1) ? FILL : RUN;
          err_drop <= 1'b0;
        end
        FILL: if (lb_valid_in && last_col && (row == ROW_PRE))
          state <= RUN;
        RUN: if (lb_valid_in && last_pix) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: 6x6 main instance plus a 5x4 instance.
module tb_line_buffer_ctrl;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, valid_in;
  logic       ready, lb_valid_in, win_valid, busy, frame_done, err_drop;
  logic [2:0] win_col, win_row;

  logic       start_s, valid_s;
  logic       ready_s, lb_valid_s, win_valid_s, busy_s, frame_done_s, err_drop_s;
  logic [2:0] win_col_s;
  logic [1:0] win_row_s;

  int vecs = 0;
  int errs = 0;

  line_buffer_ctrl #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .LINE_NUM(3)) dut (
    .clock(clock), .reset(reset), .start(start), .valid_in(valid_in),
    .ready(ready), .lb_valid_in(lb_valid_in), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row), .busy(busy),
    .frame_done(frame_done), .err_drop(err_drop)
  );

  line_buffer_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .LINE_NUM(3)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .valid_in(valid_s),
    .ready(ready_s), .lb_valid_in(lb_valid_s), .win_valid(win_valid_s),
    .win_col(win_col_s), .win_row(win_row_s), .busy(busy_s),
    .frame_done(frame_done_s), .err_drop(err_drop_s)
  );

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; valid_in = 1'b0; start_s = 1'b0; valid_s = 1'b0;
    #1;
    vecs++;
    if ({ready, lb_valid_in, win_valid, win_col, win_row, busy, frame_done, err_drop} !== 11'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %b want all zero",
               {ready, lb_valid_in, win_valid, win_col, win_row, busy, frame_done, err_drop});
    end
    vecs++;
    if ({ready_s, lb_valid_s, win_valid_s, win_col_s, win_row_s, busy_s, frame_done_s, err_drop_s} !== 10'd0) begin
      errs++;
      $display("FAIL reset_outputs_sweep: got %b want all zero",
               {ready_s, lb_valid_s, win_valid_s, win_col_s, win_row_s, busy_s, frame_done_s, err_drop_s});
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  // Runs one 6x6 frame on the main instance, starting from IDLE at a sample point.
  task automatic run_frame(input bit gap, input bit valid_with_start,
                           input int start_at, input int abort_at);
    int p, pulses, cyc, r, c;
    bit drv;
    logic [2:0] er, ec;
    start = 1'b1;
    valid_in = valid_with_start;
    #1;
    vecs++;
    if (lb_valid_in !== 1'b0) begin
      errs++; $display("FAIL start_lb_valid: got %b want 0", lb_valid_in);
    end
    @(posedge clock); #1;
    start = 1'b0; valid_in = 1'b0;
    vecs++;
    if ({ready, busy, err_drop} !== 3'b110) begin
      errs++; $display("FAIL after_start ready/busy/err_drop: got %b want 110", {ready, busy, err_drop});
    end
    p = 0; pulses = 0; cyc = 0;
    while (1) begin
      drv = (p < 36) && (!gap || (cyc % 2 == 0));
      if (drv && p == abort_at) begin
        reset = 1'b0; valid_in = 1'b1;
        #1;
        vecs++;
        if ({busy, ready, win_valid, lb_valid_in, frame_done, win_col, win_row} !== 11'd0) begin
          errs++;
          $display("FAIL abort_outputs: got %b want all zero",
                   {busy, ready, win_valid, lb_valid_in, frame_done, win_col, win_row});
        end
        @(posedge clock); #1;
        reset = 1'b1; valid_in = 1'b0;
        @(posedge clock); #1;
        vecs++;
        if ({busy, ready, err_drop} !== 3'b000) begin
          errs++; $display("FAIL post_abort_idle: got %b want 000", {busy, ready, err_drop});
        end
        return;
      end
      valid_in = drv;
      start = (drv && p == start_at);
      #1;
      vecs++;
      if (lb_valid_in !== drv) begin
        errs++; $display("FAIL lb_valid_in p=%0d: got %b want %b", p, lb_valid_in, drv);
      end
      @(posedge clock); #1;
      start = 1'b0;
      r = p / 6; c = p % 6;
      vecs++;
      if (win_valid !== (drv && r >= 2 && c >= 2)) begin
        errs++; $display("FAIL win_valid p=%0d drv=%b: got %b want %b", p, drv, win_valid, (drv && r >= 2 && c >= 2));
      end
      if (win_valid === 1'b1) pulses++;
      if (drv) begin
        er = r[2:0]; ec = c[2:0];
        vecs++;
        if ({win_row, win_col} !== {er, ec}) begin
          errs++; $display("FAIL win_pos p=%0d: got %0d,%0d want %0d,%0d", p, win_row, win_col, er, ec);
        end
        p++;
      end
      vecs++;
      if ({frame_done, busy} !== {(drv && p == 36), (p < 36)}) begin
        errs++; $display("FAIL frame_done/busy p=%0d: got %b want %b", p, {frame_done, busy}, {(drv && p == 36), (p < 36)});
      end
      if (p == 36) break;
      cyc++;
      if (cyc > 300) begin
        vecs++; errs++;
        $display("FAIL frame_timeout: got %0d pixels want 36", p);
        break;
      end
    end
    valid_in = 1'b0;
    vecs++;
    if (pulses !== 16) begin
      errs++; $display("FAIL win_pulses: got %0d want 16", pulses);
    end
    @(posedge clock); #1;
    vecs++;
    if ({frame_done, busy, ready, err_drop, win_valid} !== 5'b00000) begin
      errs++; $display("FAIL after_frame: got %b want 00000", {frame_done, busy, ready, err_drop, win_valid});
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_gaps();
    run_frame(1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_err_drop();
    valid_in = 1'b1;
    #1;
    vecs++;
    if (lb_valid_in !== 1'b0) begin
      errs++; $display("FAIL idle_lb_valid: got %b want 0", lb_valid_in);
    end
    @(posedge clock); #1;
    valid_in = 1'b0;
    vecs++;
    if (err_drop !== 1'b1) begin
      errs++; $display("FAIL err_drop_set: got %b want 1", err_drop);
    end
    @(posedge clock); #1;
    vecs++;
    if (err_drop !== 1'b1) begin
      errs++; $display("FAIL err_drop_sticky: got %b want 1", err_drop);
    end
    run_frame(1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_start_collision();
    run_frame(1'b0, 1'b1, 10, -1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 1'b0, -1, 19);
    run_frame(1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_param_sweep();
    int p, pulses, r, c;
    logic [2:0] ec;
    logic [1:0] er;
    start_s = 1'b1;
    @(posedge clock); #1;
    start_s = 1'b0;
    vecs++;
    if ({ready_s, busy_s} !== 2'b11) begin
      errs++; $display("FAIL sweep_start: got %b want 11", {ready_s, busy_s});
    end
    pulses = 0;
    for (p = 0; p < 20; p++) begin
      valid_s = 1'b1;
      @(posedge clock); #1;
      r = p / 5; c = p % 5;
      er = r[1:0]; ec = c[2:0];
      vecs++;
      if ({win_valid_s, win_row_s, win_col_s} !== {(r >= 2 && c >= 2), er, ec}) begin
        errs++;
        $display("FAIL sweep_win p=%0d: got v=%b %0d,%0d want v=%b %0d,%0d",
                 p, win_valid_s, win_row_s, win_col_s, (r >= 2 && c >= 2), er, ec);
      end
      if (win_valid_s === 1'b1) pulses++;
      vecs++;
      if (frame_done_s !== (p == 19)) begin
        errs++; $display("FAIL sweep_frame_done p=%0d: got %b want %b", p, frame_done_s, (p == 19));
      end
    end
    valid_s = 1'b0;
    vecs++;
    if (pulses !== 6) begin
      errs++; $display("FAIL sweep_pulses: got %0d want 6", pulses);
    end
    @(posedge clock); #1;
    vecs++;
    if ({frame_done_s, busy_s, err_drop_s} !== 3'b000) begin
      errs++; $display("FAIL sweep_after: got %b want 000", {frame_done_s, busy_s, err_drop_s});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_err_drop();
    test_start_collision();
    test_reset_mid_frame();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Frame sequencer for the cascaded line-buffer chain.
- Arms on a start pulse and gates the pixel stream into the first line buffer (ready/valid).
- Tracks column/row position within the frame and asserts win_valid when a full LINE_NUM x LINE_NUM window is present at the line-buffer outputs.
- Signals frame completion; sits between the pixel source and line_buffer_top / downstream window logic.

Parameters:
IMG_WIDTH, 6, pixels per line (>= LINE_NUM)
IMG_HEIGHT, 6, lines per frame (>= LINE_NUM)
LINE_NUM, 3, rows in the line cache; window size
CW, $clog2(IMG_WIDTH), column counter width (localparam)
RW, $clog2(IMG_HEIGHT), row counter width (localparam)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: arm controller for a new frame
valid_in  in  1  source pixel valid
ready  out  1  controller accepting pixels (combinational from state)
lb_valid_in  out  1  write valid to line-buffer chain = valid_in & ready
win_valid  out  1  registered; window complete for the last accepted pixel
win_col  out  CW  registered column of the last accepted pixel (window bottom-right)
win_row  out  RW  registered row of the last accepted pixel
busy  out  1  high in FILL or RUN
frame_done  out  1  one-cycle pulse after the last pixel of the frame
err_drop  out  1  sticky: valid_in seen while not ready; cleared by start

Behaviour:
- Reset (reset=0, async): state IDLE, col=row=0, all outputs 0 (ready, lb_valid_in, win_valid, win_col, win_row, busy, frame_done, err_drop).
- States: IDLE, FILL, RUN, DONE.
- IDLE:
  - ready=0.
  - start=1 -> FILL; col, row cleared; err_drop cleared.
  - valid_in=1 without start -> err_drop set; pixel not accepted.
- FILL (row < LINE_NUM-1):
  - ready=1.
  - Each accepted pixel (valid_in & ready) advances col.
  - col==IMG_WIDTH-1 -> col=0, row+1.
  - When row becomes LINE_NUM-1 -> RUN.
- RUN:
  - ready=1; same counting as FILL.
  - Accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
- DONE: ready=0, frame_done=1 for exactly this cycle; next cycle -> IDLE.
- Position/window outputs:
  - win_col/win_row: registered with the coordinates of each accepted pixel, 1-cycle latency; hold value otherwise.
  - win_valid: registered, 1 cycle after an accepted pixel with row>=LINE_NUM-1 and col>=LINE_NUM-1; 0 in all other cycles, including idle gaps (valid_in low).
- start handling:
  - start while busy or in DONE: ignored, frame continues.
  - start and valid_in same cycle in IDLE: start wins; pixel not accepted, err_drop not set.
- Line-buffer gating: lb_valid_in is never high outside FILL/RUN, so the line-buffer chain never sees a write outside a frame.
- Reset mid-frame: immediate return to IDLE, counters zero, all outputs zero. The line-buffer chain shares the reset.
- Stalls: valid_in low for any number of cycles freezes counters; no timeout.
- Wrap arithmetic: counters compare against IMG_WIDTH-1 / IMG_HEIGHT-1 explicitly (non-power-of-2 safe); no overflow past the maximum.
- busy = (state==FILL || state==RUN).
- Per frame: win_valid pulses exactly (IMG_HEIGHT-LINE_NUM+1)*(IMG_WIDTH-LINE_NUM+1) times.

Decomposition:
- Package line_buffer_pkg:
  - typedef enum logic [1:0] lb_state_t {IDLE, FILL, RUN, DONE}
  - default IMG_WIDTH / IMG_HEIGHT / LINE_NUM constants
- Sub-module lb_pos_counter:
  - col/row counters with enable, clear and wrap
  - outputs last_col, last_pix flags
- line_buffer_ctrl holds the FSM and the registered window outputs.

Test Plan:
- Reset then start; stream 36 pixels back-to-back (6x6, LINE_NUM=3) -> ready high from the cycle after start; 16 win_valid pulses, first with win_row=2,win_col=2, last with 5,5; frame_done one cycle after the final pixel; busy low after.
- Same frame with valid_in toggling 1-0 -> counters freeze on gaps; still exactly 16 win_valid pulses with identical coordinate sequence; no win_valid during gaps.
- valid_in high in IDLE without start -> lb_valid_in=0, err_drop=1 and sticky; next start clears err_drop to 0.
- start and valid_in together in IDLE -> pixel not counted (first accepted pixel reports 0,0); start pulse at pixel 10 mid-frame -> ignored, frame completes normally.
- Assert reset low at pixel 20 (row 3, col 1) -> same cycle: busy, ready, win_valid=0; after release plus start, a full 36-pixel frame yields 16 win_valid pulses.
- Parameter sweep IMG_WIDTH=5, IMG_HEIGHT=4 -> 6 win_valid pulses; columns wrap at 4; frame_done after pixel 20.
